apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH, 16, width of paddr and cmd_addr
  DATA_WIDTH, 32, width of pwdata, prdata, cmd_wdata and rsp_rdata
  TIMEOUT, 16, maximum ACCESS cycles waiting for pready; 0 disables the timeout
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  pclk  in  1  single clock; all state updates on its rising edge
  preset_n  in  1  reset, asynchronous and active-low
  cmd_valid  in  1  command request
  cmd_ready  out  1  command accepted when high together with cmd_valid
  cmd_write  in  1  1 = write, 0 = read
  cmd_addr  in  ADDR_WIDTH  transfer address
  cmd_wdata  in  DATA_WIDTH  write data
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed when high together with rsp_valid
  rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
  rsp_err  out  1  pslverr or timeout occurred
  rsp_timeout  out  1  transfer ended by timeout
  paddr  out  ADDR_WIDTH  APB address
  psel  out  1  APB select
  penable  out  1  APB enable
  pwrite  out  1  APB direction
  pwdata  out  DATA_WIDTH  APB write data
  prdata  in  DATA_WIDTH  APB read data
  pready  in  1  APB completer ready
  pslverr  in  1  APB completer error

Function
REQ-003 The FSM SHALL have the states IDLE, SETUP and ACCESS; only one transfer SHALL be outstanding at any time.
REQ-004 cmd_ready SHALL be 1 only in IDLE and only when rsp_valid=0 or rsp_ready=1 in the same cycle, so a new command can be accepted on the edge that retires the previous response.
REQ-005 On an edge with cmd_valid and cmd_ready both high: cmd_addr, cmd_write and cmd_wdata SHALL be registered onto paddr, pwrite and pwdata, and the FSM SHALL move to SETUP.
REQ-006 SETUP: psel=1, penable=0; the FSM SHALL move unconditionally to ACCESS on the next edge.
REQ-007 ACCESS: psel=1, penable=1; paddr, pwrite and pwdata SHALL stay stable until the transfer ends.
REQ-008 On an ACCESS edge with pready=1, the block SHALL:
  - set rsp_valid=1;
  - set rsp_rdata to prdata for a read, or 0 for a write;
  - set rsp_err=pslverr and rsp_timeout=0;
  - return the FSM to IDLE, so psel=0 and penable=0 in the following cycle.
REQ-009 Latency SHALL be 3 edges from command acceptance to rsp_valid with zero wait states, plus one edge per wait state.
REQ-010 The wait counter SHALL clear on entry to ACCESS and increment on each ACCESS edge with pready=0.
REQ-011 Timeout: if TIMEOUT>0 and the counter reaches TIMEOUT, the block SHALL:
  - end the transfer on that edge and return to IDLE;
  - set rsp_valid=1, rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-012 A pready arriving on the same edge that the timeout would fire SHALL take priority, and the transfer SHALL complete normally.
REQ-013 rsp_valid, rsp_rdata, rsp_err and rsp_timeout SHALL hold until rsp_valid and rsp_ready are both high; rsp_valid SHALL then clear unless a new response is produced on that same edge.
REQ-014 paddr, pwrite and pwdata SHALL retain their last values in IDLE; psel and penable SHALL both be 0 in IDLE.
REQ-015 pslverr and prdata SHALL be ignored outside ACCESS, and when pready=0.

Reset
REQ-016 While preset_n=0, all of the following SHALL be 0 immediately, independent of pclk: the FSM (IDLE), cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata and the wait counter.
REQ-017 A reset asserted during SETUP or ACCESS SHALL abort the transfer with no response; after release, cmd_ready SHALL be 1 in the first cycle.

Verification
REQ-018 Zero-wait write: cmd addr=1, wdata=10, write=1, pready=1 -> the bench SHALL check:
  - psel high for 2 cycles, penable high for the second cycle only;
  - paddr=1, pwdata=10, pwrite=1;
  - rsp_valid on the 3rd edge with rsp_err=0 and rsp_rdata=0.
REQ-019 Read with 2 wait states: cmd addr=1, read, pready low for 2 ACCESS cycles, prdata=10 -> rsp_valid on the 5th edge with rsp_rdata=10 and rsp_err=0.
REQ-020 Slave error: read of addr=7 with pslverr=1 alongside pready=1 -> rsp_err=1 and rsp_timeout=0.
REQ-021 Timeout with TIMEOUT=4 and pready held 0 -> the bench SHALL check:
  - penable drops after 4 ACCESS cycles;
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-022 Back-pressure, back-to-back: rsp_ready=0 for 3 cycles -> response fields stable and cmd_ready=0; rsp_ready=1 with a new cmd_valid -> response retired and new command accepted on the same edge.
REQ-023 Reset in ACCESS: preset_n driven low mid-transfer -> psel, penable and rsp_valid are 0 immediately; after release, the next command completes normally.

Source files
------------

// File: rtl/apb_master_if.sv
// Command/response handshake and APB completer bus for apb_master.
// The master modport is the apb_master view; slave is the environment view.
interface apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns a valid/ready command into an
// IDLE/SETUP/ACCESS transfer and returns a held response with error/timeout.
module apb_master #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic          pclk,
  input logic          preset_n,
  apb_master_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [CNT_W-1:0]      wait_q, wait_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  cmd_ready_c;
  logic                  timeout_hit_c;

  // Accept only when idle and the response slot is empty or retiring now.
  assign cmd_ready_c   = preset_n && (state_q == IDLE) &&
                         (!rsp_valid_q || bus.rsp_ready);
  assign timeout_hit_c = (TIMEOUT != 0) &&
                         ((32'(wait_q) + 32'd1) == 32'(TIMEOUT));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      wait_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      wait_q        <= wait_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    wait_d        = wait_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_c) begin
          state_d   = SETUP;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          pwrite_d  = bus.cmd_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      ACCESS: begin
        // pready wins over a timeout firing on the same edge.
        if (bus.pready) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit_c) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: zero-wait, wait states, slave error,
// timeout, pready-vs-timeout race, back-pressure and reset mid-transfer.
module tb_apb_master;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic pclk     = 1'b0;
  logic preset_n = 1'b0;

  always #5 pclk = ~pclk;

  apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus.master)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Present one command, confirm it is accepted on the next edge.
  task automatic send(input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    #1;
    check("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic retire();
    bus.rsp_ready = 1'b1;
    step();
    check("rsp_retired", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    // Reset state
    #2;
    check("rst_psel",      32'(bus.psel),      32'd0);
    check("rst_penable",   32'(bus.penable),   32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_paddr",     32'(bus.paddr),     32'd0);
    step();
    step();
    preset_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Zero-wait write
    bus.pready = 1'b1;
    send(1'b1, 16'd1, 32'd10);
    check("wr_setup_psel",    32'(bus.psel),      32'd1);
    check("wr_setup_penable", 32'(bus.penable),   32'd0);
    check("wr_paddr",         32'(bus.paddr),     32'd1);
    check("wr_pwdata",        bus.pwdata,         32'd10);
    check("wr_pwrite",        32'(bus.pwrite),    32'd1);
    check("wr_setup_rsp",     32'(bus.rsp_valid), 32'd0);
    step();
    check("wr_access_psel",    32'(bus.psel),      32'd1);
    check("wr_access_penable", 32'(bus.penable),   32'd1);
    check("wr_access_rsp",     32'(bus.rsp_valid), 32'd0);
    step();
    check("wr_rsp_valid",   32'(bus.rsp_valid),   32'd1);
    check("wr_rsp_err",     32'(bus.rsp_err),     32'd0);
    check("wr_rsp_rdata",   bus.rsp_rdata,        32'd0);
    check("wr_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("wr_idle_psel",   32'(bus.psel),        32'd0);
    check("wr_idle_pen",    32'(bus.penable),     32'd0);
    check("wr_idle_paddr",  32'(bus.paddr),       32'd1);
    check("wr_idle_pwdata", bus.pwdata,           32'd10);
    retire();

    // Read with two wait states; noise on prdata/pslverr while pready=0
    bus.pready  = 1'b0;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'hDEAD;
    send(1'b0, 16'd1, 32'd0);
    step();
    check("rd2_access_pen", 32'(bus.penable),   32'd1);
    step();
    check("rd2_wait1_rsp",  32'(bus.rsp_valid), 32'd0);
    check("rd2_wait1_pen",  32'(bus.penable),   32'd1);
    step();
    check("rd2_wait2_rsp",  32'(bus.rsp_valid), 32'd0);
    bus.pready  = 1'b1;
    bus.pslverr = 1'b0;
    bus.prdata  = 32'd10;
    step();
    check("rd2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rd2_rsp_rdata", bus.rsp_rdata,      32'd10);
    check("rd2_rsp_err",   32'(bus.rsp_err),   32'd0);
    retire();

    // Slave error
    bus.pslverr = 1'b1;
    bus.prdata  = 32'h55;
    send(1'b0, 16'd7, 32'd0);
    step();
    step();
    check("err_rsp_valid",   32'(bus.rsp_valid),   32'd1);
    check("err_rsp_err",     32'(bus.rsp_err),     32'd1);
    check("err_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("err_rsp_rdata",   bus.rsp_rdata,        32'h55);
    bus.pslverr = 1'b0;
    retire();

    // Timeout after TO ACCESS cycles
    bus.pready = 1'b0;
    bus.prdata = 32'h77;
    send(1'b0, 16'd2, 32'd0);
    step();
    step();
    step();
    step();
    check("to_last_access_pen", 32'(bus.penable),   32'd1);
    check("to_last_access_rsp", 32'(bus.rsp_valid), 32'd0);
    step();
    check("to_penable",     32'(bus.penable),     32'd0);
    check("to_psel",        32'(bus.psel),        32'd0);
    check("to_rsp_valid",   32'(bus.rsp_valid),   32'd1);
    check("to_rsp_err",     32'(bus.rsp_err),     32'd1);
    check("to_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
    check("to_rsp_rdata",   bus.rsp_rdata,        32'd0);
    retire();

    // pready on the edge the timeout would fire completes normally
    send(1'b0, 16'd4, 32'd0);
    step();
    step();
    step();
    step();
    bus.pready = 1'b1;
    bus.prdata = 32'h44;
    step();
    check("race_rsp_valid",   32'(bus.rsp_valid),   32'd1);
    check("race_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("race_rsp_err",     32'(bus.rsp_err),     32'd0);
    check("race_rsp_rdata",   bus.rsp_rdata,        32'h44);

    // Back-pressure with a queued command, then retire and accept together
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 16'd3;
    bus.cmd_wdata = 32'h33;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_rdata", bus.rsp_rdata,      32'h44);
      check("bp_psel",      32'(bus.psel),      32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_cmd_ready_retire", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("bp_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
    check("bp_new_psel",    32'(bus.psel),      32'd1);
    check("bp_new_paddr",   32'(bus.paddr),     32'd3);
    check("bp_new_pwdata",  bus.pwdata,         32'h33);
    step();
    step();
    check("bp_new_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_new_rsp_rdata", bus.rsp_rdata,      32'd0);
    retire();

    // Reset asserted during ACCESS
    bus.pready = 1'b0;
    send(1'b0, 16'd5, 32'd0);
    step();
    check("rstacc_pen", 32'(bus.penable), 32'd1);
    preset_n = 1'b0;
    #1;
    check("rstacc_psel",      32'(bus.psel),      32'd0);
    check("rstacc_penable",   32'(bus.penable),   32'd0);
    check("rstacc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstacc_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rstacc_paddr",     32'(bus.paddr),     32'd0);
    step();
    step();
    preset_n = 1'b1;
    #1;
    check("rstacc_release_ready", 32'(bus.cmd_ready), 32'd1);
    check("rstacc_release_rsp",   32'(bus.rsp_valid), 32'd0);
    bus.pready = 1'b1;
    bus.prdata = 32'h99;
    send(1'b0, 16'd9, 32'd0);
    step();
    step();
    check("rstacc_rd_valid", 32'(bus.rsp_valid), 32'd1);
    check("rstacc_rd_rdata", bus.rsp_rdata,      32'h99);
    check("rstacc_rd_err",   32'(bus.rsp_err),   32'd0);
    retire();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
